// File: rtl/dk_sprite_addr_gen_if.sv
// rtl/dk_sprite_addr_gen_if.sv - scan/position/pose bundle between the VGA timing side and the sprite address stage
interface dk_sprite_addr_gen_if;
  logic       pixel_en;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       frame_start;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic       face_left;
  logic       anim_hold;
  logic       blink;
  logic [9:0] horz;
  logic [9:0] vert;
  logic       in_sprite;
  logic [1:0] anim_frame;

  modport master (
    output pixel_en, hcount, vcount, frame_start,
    output pos_x, pos_y, face_left, anim_hold, blink,
    input  horz, vert, in_sprite, anim_frame
  );

  modport slave (
    input  pixel_en, hcount, vcount, frame_start,
    input  pos_x, pos_y, face_left, anim_hold, blink,
    output horz, vert, in_sprite, anim_frame
  );
endinterface

// File: rtl/dk_sprite_addr_gen.sv
// rtl/dk_sprite_addr_gen.sv - sprite ROM row/column address, window flag and pose index generator
// Optional blinking is built only when DK_SPRITE_BLINK_EN is defined.
module dk_sprite_addr_gen #(
  parameter int SPR_W        = 64,
  parameter int SPR_H        = 32,
  parameter int ANIM_PERIOD  = 8,
  parameter int NUM_FRAMES   = 2,
  parameter int BLINK_PERIOD = 16
) (
  input logic clk,
  input logic reset,
  dk_sprite_addr_gen_if.slave bus
);

  localparam int ACW = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
  localparam logic [10:0]    SPR_W11   = 11'(SPR_W);
  localparam logic [10:0]    SPR_H11   = 11'(SPR_H);
  localparam logic [9:0]     SPR_W_M1  = 10'(SPR_W - 1);
  localparam logic [ACW-1:0] ANIM_LAST = ACW'(ANIM_PERIOD - 1);
  localparam logic [1:0]     POSE_LAST = 2'(NUM_FRAMES - 1);

  logic [9:0]     x_q;
  logic [9:0]     y_q;
  logic           face_q;
  logic [9:0]     horz_q;
  logic [9:0]     vert_q;
  logic           in_sprite_q;
  logic [ACW-1:0] anim_cnt;
  logic [1:0]     anim_frame_q;

  logic [10:0] h11;
  logic [10:0] v11;
  logic [10:0] x11;
  logic [10:0] y11;
  logic        in_window;
  logic        hide;
  logic        show;
  logic [9:0]  dx;
  logic [9:0]  dy;
  logic [9:0]  horz_n;

  // Shadow position/facing: the scan always sees the values captured at the last frame_start.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q    <= '0;
      y_q    <= '0;
      face_q <= 1'b0;
    end else if (bus.frame_start) begin
      x_q    <= bus.pos_x;
      y_q    <= bus.pos_y;
      face_q <= bus.face_left;
    end
  end

`ifdef DK_SPRITE_BLINK_EN
  localparam int BCW = $clog2(2 * BLINK_PERIOD);
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(2 * BLINK_PERIOD - 1);
  localparam logic [BCW-1:0] BLINK_HALF = BCW'(BLINK_PERIOD);

  logic [BCW-1:0] blink_cnt;

  always_ff @(posedge clk) begin
    if (reset || !bus.blink) begin
      blink_cnt <= '0;
    end else if (bus.frame_start) begin
      blink_cnt <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
    end
  end

  assign hide = bus.blink && (blink_cnt >= BLINK_HALF);
`else
  logic unused_blink;
  assign unused_blink = bus.blink;
  assign hide = 1'b0;
`endif

  // 11-bit compare so x+SPR_W past column 799 clips instead of wrapping.
  always_comb begin
    h11       = {1'b0, bus.hcount};
    v11       = {1'b0, bus.vcount};
    x11       = {1'b0, x_q};
    y11       = {1'b0, y_q};
    in_window = (h11 >= x11) && (h11 < x11 + SPR_W11) &&
                (v11 >= y11) && (v11 < y11 + SPR_H11);
    show      = in_window && !hide;
    dx        = bus.hcount - x_q;
    dy        = bus.vcount - y_q;
    horz_n    = face_q ? (SPR_W_M1 - dx) : dx;
  end

  // Addresses are forced to 0 outside the window so the ROM never sees an out-of-range index.
  always_ff @(posedge clk) begin
    if (reset) begin
      horz_q      <= '0;
      vert_q      <= '0;
      in_sprite_q <= 1'b0;
    end else if (bus.pixel_en) begin
      horz_q      <= show ? horz_n : '0;
      vert_q      <= show ? dy : '0;
      in_sprite_q <= show;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      anim_cnt     <= '0;
      anim_frame_q <= '0;
    end else if (bus.frame_start && !bus.anim_hold) begin
      if (anim_cnt == ANIM_LAST) begin
        anim_cnt     <= '0;
        anim_frame_q <= (anim_frame_q == POSE_LAST) ? 2'd0 : anim_frame_q + 2'd1;
      end else begin
        anim_cnt <= anim_cnt + 1'b1;
      end
    end
  end

  assign bus.horz       = horz_q;
  assign bus.vert       = vert_q;
  assign bus.in_sprite  = in_sprite_q;
  assign bus.anim_frame = anim_frame_q;

endmodule

// File: tb/tb_dk_sprite_addr_gen.sv
// tb/tb_dk_sprite_addr_gen.sv - directed checks of window, mirroring, frame latch, clipping and animation
module tb_dk_sprite_addr_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  dk_sprite_addr_gen_if bus ();

  dk_sprite_addr_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic check_out(input string tag, input int h, input int v, input int s);
    check({tag, ".horz"}, 32'(bus.horz), 32'(h));
    check({tag, ".vert"}, 32'(bus.vert), 32'(v));
    check({tag, ".in"}, 32'(bus.in_sprite), 32'(s));
  endtask

  task automatic scan(input int h, input int v);
    @(negedge clk);
    bus.pixel_en    = 1'b1;
    bus.frame_start = 1'b0;
    bus.hcount      = 10'(h);
    bus.vcount      = 10'(v);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.pixel_en    = 1'b0;
      bus.frame_start = 1'b1;
      @(negedge clk);
      bus.frame_start = 1'b0;
    end
    #1;
  endtask

  task automatic set_pos(input int x, input int y, input logic f);
    bus.pos_x     = 10'(x);
    bus.pos_y     = 10'(y);
    bus.face_left = f;
  endtask

  initial begin
    bus.pixel_en = 1'b0; bus.hcount = '0; bus.vcount = '0; bus.frame_start = 1'b0;
    bus.pos_x = '0; bus.pos_y = '0; bus.face_left = 1'b0; bus.anim_hold = 1'b0; bus.blink = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 0, 0, 0);
    check("reset.anim", 32'(bus.anim_frame), 0);
    @(negedge clk);
    reset = 1'b0;

    set_pos(100, 50, 1'b0);
    pulse(1);
    scan(100, 50);  check_out("tl", 0, 0, 1);
    @(negedge clk);
    bus.pixel_en = 1'b0; bus.hcount = 10'd164;
    @(posedge clk); #1;
    check_out("hold", 0, 0, 1);
    scan(163, 81);  check_out("br", 63, 31, 1);
    scan(164, 81);  check_out("right_out", 0, 0, 0);
    scan(99, 50);   check_out("left_out", 0, 0, 0);
    scan(100, 82);  check_out("below_out", 0, 0, 0);
    scan(120, 60);  check_out("mid", 20, 10, 1);

    set_pos(100, 50, 1'b1);
    pulse(1);
    scan(100, 50);  check_out("mir_l", 63, 0, 1);
    scan(163, 50);  check_out("mir_r", 0, 0, 1);
    scan(110, 70);  check_out("mir_m", 53, 20, 1);

    set_pos(200, 50, 1'b0);
    scan(100, 50);  check_out("nolatch_old", 63, 0, 1);
    scan(200, 50);  check_out("nolatch_new", 0, 0, 0);
    pulse(1);
    scan(200, 50);  check_out("latch_new", 0, 0, 1);
    scan(100, 50);  check_out("latch_old", 0, 0, 0);

    set_pos(300, 50, 1'b0);
    @(negedge clk);
    bus.pixel_en = 1'b1; bus.frame_start = 1'b1; bus.hcount = 10'd200; bus.vcount = 10'd50;
    @(posedge clk); #1;
    check_out("simul_old", 0, 0, 1);
    scan(200, 50);  check_out("simul_after", 0, 0, 0);
    scan(300, 50);  check_out("simul_new", 0, 0, 1);

    set_pos(780, 510, 1'b0);
    pulse(1);
    scan(799, 524); check_out("edge_br", 19, 14, 1);
    scan(780, 510); check_out("edge_tl", 0, 0, 1);
    scan(0, 0);     check_out("nowrap_00", 0, 0, 0);
    scan(0, 524);   check_out("nowrap_col", 0, 0, 0);
    scan(799, 0);   check_out("nowrap_row", 0, 0, 0);

    scan(799, 524);
    @(negedge clk);
    reset = 1'b1; bus.pixel_en = 1'b1;
    @(posedge clk); #1;
    check_out("midreset", 0, 0, 0);
    check("midreset.anim", 32'(bus.anim_frame), 0);
    @(negedge clk);
    reset = 1'b0;
    scan(799, 524); check_out("post_reset_old", 0, 0, 0);
    scan(5, 7);     check_out("post_reset_origin", 5, 7, 1);

    pulse(7);  check("anim_p7", 32'(bus.anim_frame), 0);
    pulse(1);  check("anim_p8", 32'(bus.anim_frame), 1);
    pulse(7);  check("anim_p15", 32'(bus.anim_frame), 1);
    pulse(1);  check("anim_p16", 32'(bus.anim_frame), 0);
    bus.anim_hold = 1'b1;
    pulse(8);  check("anim_hold8", 32'(bus.anim_frame), 0);
    pulse(4);  check("anim_hold12", 32'(bus.anim_frame), 0);
    bus.anim_hold = 1'b0;
    pulse(7);  check("anim_rel7", 32'(bus.anim_frame), 0);
    pulse(1);  check("anim_rel8", 32'(bus.anim_frame), 1);

`ifdef DK_SPRITE_BLINK_EN
    set_pos(0, 0, 1'b0);
    pulse(1);
    bus.blink = 1'b1;
    for (int f = 0; f < 34; f++) begin
      scan(3, 4);
      check($sformatf("blink_f%0d", f), 32'(bus.in_sprite), ((f % 32) < 16) ? 1 : 0);
      pulse(1);
    end
    bus.blink = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
